// File: rtl/am2900_pkg.sv
// Shared constants for the Am2910-style next-address controller:
// next-address opcodes and sequencer source-select encodings.
package am2900_pkg;

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,
        OP_CJS  = 4'd1,
        OP_JMAP = 4'd2,
        OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,
        OP_JSRP = 4'd5,
        OP_CJV  = 4'd6,
        OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,
        OP_RPCT = 4'd9,
        OP_CRTN = 4'd10,
        OP_CJPP = 4'd11,
        OP_LDCT = 4'd12,
        OP_LOOP = 4'd13,
        OP_CONT = 4'd14,
        OP_TWB  = 4'd15
    } op_e;

    localparam logic [1:0] S_UPC = 2'b00;
    localparam logic [1:0] S_AR  = 2'b01;
    localparam logic [1:0] S_STK = 2'b10;
    localparam logic [1:0] S_D   = 2'b11;

    localparam logic [2:0] STK_MAX = 3'd4;

endpackage

// File: rtl/loop_counter.sv
// 8-bit loop counter with load, non-wrapping decrement and zero flag.
// Load wins over decrement.
module loop_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] d,
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= d;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/next_address_ctrl.sv
// Next-address instruction decoder driving an Am2909/2911 sequencer,
// with loop counter and tracked stack depth / sticky stack error.
module next_address_ctrl
    import am2900_pkg::*;
(
    input  logic       CP,
    input  logic       RST,
    input  logic [3:0] I,
    input  logic       TEST,
    input  logic       POL,
    input  logic [7:0] CNT_D,
    output logic [1:0] S,
    output logic       FE,
    output logic       PUP,
    output logic       RE,
    output logic       ZERO,
    output logic       PL_OE,
    output logic       MAP_OE,
    output logic       VECT_OE,
    output logic       CNT_ZERO,
    output logic [2:0] DEPTH,
    output logic       STK_ERR
);

    op_e        op;
    logic       pass;
    logic       push_req;
    logic       pop_req;
    logic       push_ok;
    logic       pop_ok;
    logic       stk_fault;
    logic       cnt_load;
    logic       cnt_dec;
    logic [2:0] depth;
    logic       stk_err;

    assign op   = op_e'(I);
    assign pass = TEST ^ POL;

    always_comb begin
        S        = S_UPC;
        RE       = 1'b1;
        ZERO     = 1'b1;
        PL_OE    = 1'b0;
        MAP_OE   = 1'b1;
        VECT_OE  = 1'b1;
        push_req = 1'b0;
        pop_req  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (op)
            OP_JZ:   ZERO = 1'b0;
            OP_CJS: begin
                if (pass) begin
                    S        = S_D;
                    push_req = 1'b1;
                end
            end
            OP_JMAP: begin
                S      = S_D;
                MAP_OE = 1'b0;
                PL_OE  = 1'b1;
            end
            OP_CJP:  if (pass) S = S_D;
            OP_PUSH: begin
                push_req = 1'b1;
                cnt_load = pass;
            end
            OP_JSRP: begin
                S        = pass ? S_D : S_AR;
                push_req = 1'b1;
            end
            OP_CJV: begin
                if (pass) begin
                    S       = S_D;
                    VECT_OE = 1'b0;
                    PL_OE   = 1'b1;
                end
            end
            OP_JRP:  S = pass ? S_D : S_AR;
            OP_RFCT: begin
                if (!CNT_ZERO) begin
                    S       = S_STK;
                    cnt_dec = 1'b1;
                end else begin
                    pop_req = 1'b1;
                end
            end
            OP_RPCT: begin
                if (!CNT_ZERO) begin
                    S       = S_D;
                    cnt_dec = 1'b1;
                end
            end
            OP_CRTN: begin
                if (pass) begin
                    S       = S_STK;
                    pop_req = 1'b1;
                end
            end
            OP_CJPP: begin
                if (pass) begin
                    S       = S_D;
                    pop_req = 1'b1;
                end
            end
            OP_LDCT: begin
                cnt_load = 1'b1;
                RE       = 1'b0;
            end
            OP_LOOP: begin
                if (pass) pop_req = 1'b1;
                else      S = S_STK;
            end
            OP_CONT: S = S_UPC;
            OP_TWB: begin
                if (pass) begin
                    S       = S_D;
                    pop_req = 1'b1;
                end else if (!CNT_ZERO) begin
                    S       = S_STK;
                    cnt_dec = 1'b1;
                end else begin
                    pop_req = 1'b1;
                end
            end
        endcase
        // Reset restarts the sequencer at address 0 and cancels all state ops
        if (RST) begin
            S        = S_UPC;
            RE       = 1'b1;
            ZERO     = 1'b0;
            PL_OE    = 1'b0;
            MAP_OE   = 1'b1;
            VECT_OE  = 1'b1;
            push_req = 1'b0;
            pop_req  = 1'b0;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    assign push_ok   = push_req && (depth != STK_MAX);
    assign pop_ok    = pop_req && (depth != 3'd0);
    assign stk_fault = (push_req && !push_ok) || (pop_req && !pop_ok);

    assign FE  = !(push_ok || pop_ok);
    assign PUP = push_ok;

    always_ff @(posedge CP) begin
        if (RST) begin
            depth   <= '0;
            stk_err <= 1'b0;
        end else begin
            if (push_ok)     depth <= depth + 3'd1;
            else if (pop_ok) depth <= depth - 3'd1;
            if (stk_fault)   stk_err <= 1'b1;
        end
    end

    loop_counter u_cnt (
        .clk  (CP),
        .rst  (RST),
        .load (cnt_load),
        .dec  (cnt_dec),
        .d    (CNT_D),
        .zero (CNT_ZERO)
    );

    assign DEPTH   = depth;
    assign STK_ERR = stk_err;

endmodule

// File: tb/tb_next_address_ctrl.sv
// Directed table-driven bench for next_address_ctrl plus hand-written
// reset and stack-underflow sequences.
module tb_next_address_ctrl;

    logic       CP = 1'b0;
    logic       RST;
    logic [3:0] I;
    logic       TEST;
    logic       POL;
    logic [7:0] CNT_D;
    logic [1:0] S;
    logic       FE;
    logic       PUP;
    logic       RE;
    logic       ZERO;
    logic       PL_OE;
    logic       MAP_OE;
    logic       VECT_OE;
    logic       CNT_ZERO;
    logic [2:0] DEPTH;
    logic       STK_ERR;

    int n_vec = 0;
    int n_bad = 0;

    next_address_ctrl dut (
        .CP       (CP),
        .RST      (RST),
        .I        (I),
        .TEST     (TEST),
        .POL      (POL),
        .CNT_D    (CNT_D),
        .S        (S),
        .FE       (FE),
        .PUP      (PUP),
        .RE       (RE),
        .ZERO     (ZERO),
        .PL_OE    (PL_OE),
        .MAP_OE   (MAP_OE),
        .VECT_OE  (VECT_OE),
        .CNT_ZERO (CNT_ZERO),
        .DEPTH    (DEPTH),
        .STK_ERR  (STK_ERR)
    );

    always #5 CP = ~CP;

    // expected word: {S,FE,PUP,RE,ZERO,PL_OE,MAP_OE,VECT_OE,CNT_ZERO,DEPTH,STK_ERR}
    typedef struct {
        logic [3:0]  i;
        logic        test;
        logic        pol;
        logic [7:0]  cnt_d;
        logic [13:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [13:0] ew(
        input logic [1:0] s, input logic fe, input logic pup,
        input logic re, input logic zero, input logic pl,
        input logic map, input logic vect, input logic cz,
        input logic [2:0] dp, input logic er);
        return {s, fe, pup, re, zero, pl, map, vect, cz, dp, er};
    endfunction

    function automatic vec_t mk(
        input logic [3:0] i, input logic t, input logic p,
        input logic [7:0] d, input logic [13:0] e);
        vec_t v;
        v.i = i; v.test = t; v.pol = p; v.cnt_d = d; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [13:0] exp,
                         input logic [13:0] mask);
        logic [13:0] got;
        got = {S, FE, PUP, RE, ZERO, PL_OE, MAP_OE, VECT_OE,
               CNT_ZERO, DEPTH, STK_ERR};
        n_vec++;
        if ((got & mask) !== (exp & mask)) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (mask %b)", name, got, exp, mask);
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] i, input logic t,
                         input logic p, input logic [7:0] d);
        RST = r; I = i; TEST = t; POL = p; CNT_D = d;
    endtask

    task automatic step;
        @(posedge CP);
        #1;
    endtask

    localparam logic [13:0] ALL = 14'h3fff;

    initial begin
        // reset with a would-be push on I: outputs forced, state cleared
        apply(1'b1, 4'd1, 1'b1, 1'b0, 8'd0);
        @(negedge CP);
        check("rst_outputs", ew(2'd0,1,0,1,0,0,1,1, 0,3'd0,0), 14'h3fe0);
        step;
        apply(1'b1, 4'd1, 1'b1, 1'b0, 8'd0);
        @(negedge CP);
        check("rst_state", ew(2'd0,1,0,1,0,0,1,1, 1,3'd0,0), ALL);
        step;

        //           I  T P  D     S     FE PU RE Z PL MP VC CZ DP   ER
        vq.push_back(mk(12,0,0,3, ew(2'd0,1,0,0,1,0,1,1, 1,3'd0,0)));
        vq.push_back(mk( 9,0,0,0, ew(2'd3,1,0,1,1,0,1,1, 0,3'd0,0)));
        vq.push_back(mk( 9,0,0,0, ew(2'd3,1,0,1,1,0,1,1, 0,3'd0,0)));
        vq.push_back(mk( 9,0,0,0, ew(2'd3,1,0,1,1,0,1,1, 0,3'd0,0)));
        vq.push_back(mk( 9,0,0,0, ew(2'd0,1,0,1,1,0,1,1, 1,3'd0,0)));
        vq.push_back(mk( 1,1,0,0, ew(2'd3,0,1,1,1,0,1,1, 1,3'd0,0)));
        vq.push_back(mk( 1,1,0,0, ew(2'd3,0,1,1,1,0,1,1, 1,3'd1,0)));
        vq.push_back(mk( 1,1,0,0, ew(2'd3,0,1,1,1,0,1,1, 1,3'd2,0)));
        vq.push_back(mk( 1,1,0,0, ew(2'd3,0,1,1,1,0,1,1, 1,3'd3,0)));
        vq.push_back(mk( 1,1,0,0, ew(2'd3,1,0,1,1,0,1,1, 1,3'd4,0)));
        vq.push_back(mk( 1,0,0,0, ew(2'd0,1,0,1,1,0,1,1, 1,3'd4,1)));
        vq.push_back(mk(10,1,1,0, ew(2'd0,1,0,1,1,0,1,1, 1,3'd4,1)));
        vq.push_back(mk(10,0,1,0, ew(2'd2,0,0,1,1,0,1,1, 1,3'd4,1)));
        vq.push_back(mk( 2,0,0,0, ew(2'd3,1,0,1,1,1,0,1, 1,3'd3,1)));
        vq.push_back(mk( 6,1,0,0, ew(2'd3,1,0,1,1,1,1,0, 1,3'd3,1)));
        vq.push_back(mk( 6,0,0,0, ew(2'd0,1,0,1,1,0,1,1, 1,3'd3,1)));
        vq.push_back(mk( 0,0,0,0, ew(2'd0,1,0,1,0,0,1,1, 1,3'd3,1)));
        vq.push_back(mk( 3,1,0,0, ew(2'd3,1,0,1,1,0,1,1, 1,3'd3,1)));
        vq.push_back(mk( 3,0,0,0, ew(2'd0,1,0,1,1,0,1,1, 1,3'd3,1)));
        vq.push_back(mk( 7,0,0,0, ew(2'd1,1,0,1,1,0,1,1, 1,3'd3,1)));
        vq.push_back(mk( 7,1,0,0, ew(2'd3,1,0,1,1,0,1,1, 1,3'd3,1)));
        vq.push_back(mk( 5,0,0,0, ew(2'd1,0,1,1,1,0,1,1, 1,3'd3,1)));
        vq.push_back(mk( 5,1,0,0, ew(2'd3,1,0,1,1,0,1,1, 1,3'd4,1)));
        vq.push_back(mk(11,1,0,0, ew(2'd3,0,0,1,1,0,1,1, 1,3'd4,1)));
        vq.push_back(mk(13,0,0,0, ew(2'd2,1,0,1,1,0,1,1, 1,3'd3,1)));
        vq.push_back(mk(13,1,0,0, ew(2'd0,0,0,1,1,0,1,1, 1,3'd3,1)));
        vq.push_back(mk(14,0,0,0, ew(2'd0,1,0,1,1,0,1,1, 1,3'd2,1)));
        vq.push_back(mk( 4,1,0,2, ew(2'd0,0,1,1,1,0,1,1, 1,3'd2,1)));
        vq.push_back(mk(15,0,0,0, ew(2'd2,1,0,1,1,0,1,1, 0,3'd3,1)));
        vq.push_back(mk(15,1,0,0, ew(2'd3,0,0,1,1,0,1,1, 0,3'd3,1)));
        vq.push_back(mk( 8,0,0,0, ew(2'd2,1,0,1,1,0,1,1, 0,3'd2,1)));
        vq.push_back(mk( 8,0,0,0, ew(2'd0,0,0,1,1,0,1,1, 1,3'd2,1)));
        vq.push_back(mk(15,0,0,0, ew(2'd0,0,0,1,1,0,1,1, 1,3'd1,1)));
        vq.push_back(mk( 4,0,0,9, ew(2'd0,0,1,1,1,0,1,1, 1,3'd0,1)));
        vq.push_back(mk(14,0,0,0, ew(2'd0,1,0,1,1,0,1,1, 1,3'd1,1)));

        foreach (vq[k]) begin
            apply(1'b0, vq[k].i, vq[k].test, vq[k].pol, vq[k].cnt_d);
            @(negedge CP);
            check($sformatf("vec%0d_op%0d", k, vq[k].i), vq[k].exp, ALL);
            step;
        end

        // reset mid-loop: loaded count and pending push are abandoned
        apply(1'b0, 4'd12, 1'b0, 1'b0, 8'd5);
        @(negedge CP);
        check("ldct5", ew(2'd0,1,0,0,1,0,1,1, 1,3'd1,1), ALL);
        step;
        apply(1'b1, 4'd9, 1'b1, 1'b0, 8'd0);
        @(negedge CP);
        check("rst_midloop", ew(2'd0,1,0,1,0,0,1,1, 0,3'd1,1), ALL);
        step;
        apply(1'b0, 4'd8, 1'b0, 1'b0, 8'd0);
        @(negedge CP);
        check("rfct_underflow", ew(2'd0,1,0,1,1,0,1,1, 1,3'd0,0), ALL);
        step;
        apply(1'b0, 4'd14, 1'b0, 1'b0, 8'd0);
        @(negedge CP);
        check("err_set", ew(2'd0,1,0,1,1,0,1,1, 1,3'd0,1), ALL);
        step;
        apply(1'b0, 4'd3, 1'b1, 1'b0, 8'd0);
        @(negedge CP);
        check("err_sticky", ew(2'd3,1,0,1,1,0,1,1, 1,3'd0,1), ALL);
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/next_address_ctrl.md
NEXT_ADDRESS_CTRL -- requirements
Module: next_address_ctrl

Interface
REQ-001 The block SHALL have one clock, CP, and a synchronous, active-high reset, RST.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- CP  in  1  common clock, rising edge
- RST  in  1  synchronous reset, active high
- I  in  4  next-address instruction from the pipeline register
- TEST  in  1  condition input
- POL  in  1  condition polarity; PASS = TEST XOR POL
- CNT_D  in  8  loop-count load value from the pipeline register
- S  out  2  sequencer source select: 00 uPC, 01 AR, 10 stack, 11 D
- FE  out  1  stack enable, active low
- PUP  out  1  1 = push, 0 = pop
- RE  out  1  address-register load, active low
- ZERO  out  1  forces sequencer Y to 0, active low
- PL_OE  out  1  pipeline branch field drives D, active low
- MAP_OE  out  1  mapping PROM drives D, active low
- VECT_OE  out  1  vector source drives D, active low
- CNT_ZERO  out  1  loop counter equals 0
- DEPTH  out  3  tracked sequencer stack depth, 0..4
- STK_ERR  out  1  sticky stack overflow/underflow flag

Function
REQ-003 All control outputs SHALL be combinational from I, PASS, CNT_ZERO and DEPTH; state (counter, depth, STK_ERR) SHALL update only on a CP rising edge.
REQ-004 Defaults unless overridden: S=00, FE=1, PUP=0, RE=1, ZERO=1, PL_OE=0, MAP_OE=1, VECT_OE=1, counter hold.
REQ-005 Decode (push = FE=0 with PUP=1; pop = FE=0 with PUP=0):
- 0 JZ: ZERO=0; stack and counter hold
- 1 CJS: PASS -> S=11, push; else S=00
- 2 JMAP: S=11, MAP_OE=0, PL_OE=1
- 3 CJP: PASS -> S=11; else S=00
- 4 PUSH: S=00, push; PASS -> load counter
- 5 JSRP: PASS -> S=11; else S=01; push
- 6 CJV: PASS -> S=11, VECT_OE=0, PL_OE=1; else S=00
- 7 JRP: PASS -> S=11; else S=01
- 8 RFCT: CNT!=0 -> S=10, decrement; else S=00, pop
- 9 RPCT: CNT!=0 -> S=11, decrement; else S=00
- 10 CRTN: PASS -> S=10, pop; else S=00
- 11 CJPP: PASS -> S=11, pop; else S=00
- 12 LDCT: S=00, load counter, RE=0
- 13 LOOP: PASS -> S=00, pop; else S=10
- 14 CONT: S=00
- 15 TWB: PASS -> S=11, pop; CNT!=0 -> S=10, decrement; else S=00, pop
REQ-006 The counter SHALL be 8-bit unsigned; load takes CNT_D; decrement is issued only when CNT!=0, so it never wraps; CNT_ZERO = (counter == 0).
REQ-007 DEPTH SHALL increment on an issued push and decrement on an issued pop.
REQ-008 A push at DEPTH=4 or a pop at DEPTH=0 SHALL be suppressed (FE=1, PUP=0, DEPTH held), and STK_ERR SHALL set on that edge; all other outputs follow REQ-005.
REQ-009 STK_ERR SHALL remain set until RST.
REQ-010 A counter load and a decrement SHALL never occur together; a load has priority by construction of REQ-005.

Reset
REQ-011 On a CP edge with RST=1: counter=0, DEPTH=0, STK_ERR=0.
REQ-012 While RST=1, outputs SHALL be S=00, FE=1, PUP=0, RE=1, ZERO=0, PL_OE=0, MAP_OE=1, VECT_OE=1, regardless of I, so that the sequencer restarts at address 0.
REQ-013 Reset asserted mid-loop SHALL abandon the loop; no pending decrement or stack operation completes.

Structure
REQ-014 Opcode constants (0..15) and S encodings SHALL reside in the shared package am2900_pkg.
REQ-015 The 8-bit counter SHALL be the sub-module loop_counter (load, decrement, zero flag); decode and depth tracking SHALL remain in next_address_ctrl.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- RST=1, I=1, TEST=1 -> S=00, ZERO=0, FE=1; after release DEPTH=0, CNT_ZERO=1, STK_ERR=0.
- LDCT with CNT_D=3, then RPCT for 4 cycles -> S=11,11,11,00; counter 3->2->1->0, then holds.
- CJS with PASS=1 five times -> first four push (DEPTH 1..4), fifth FE=1, DEPTH=4, STK_ERR=1.
- CRTN with POL=1, TEST=1 (fail) -> S=00, FE=1; TEST=0 (pass) -> S=10, pop, DEPTH decrements.
- DEPTH=0 with RFCT at CNT=0 -> S=00, pop suppressed, STK_ERR=1.
- JMAP -> S=11, MAP_OE=0, PL_OE=1, VECT_OE=1; CJV pass -> VECT_OE=0, PL_OE=1.
